// File: rtl/mips_icache_pkg.sv
// mips_icache_pkg: shared definitions for the direct-mapped instruction cache.
//   - default geometry (lines, words per line)
//   - refill FSM state encoding
//   - saturating increment used by the optional performance counters
package mips_icache_pkg;

    localparam int DEF_LINES          = 16;
    localparam int DEF_WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mips_icache_data_ram.sv
// icache_data_ram: instruction data store, one 32-bit word per entry.
//   clk   : clock
//   en    : access enable (read or write)
//   we    : write when en=1, otherwise read
//   addr  : word address {line, word}
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read; holds otherwise
module icache_data_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mips_icache.sv
// mips_icache: direct-mapped instruction cache with line refill.
//   clk, rst            : clock, synchronous active-high reset
//   en                  : pipeline enable; gates acceptance of a new pc
//   pc                  : fetch address (bits [1:0] ignored)
//   flush               : invalidate every line
//   instr, stall        : instruction for the last accepted pc; stall=1 while it is not ready
//   mem_req, mem_addr   : refill request and line-aligned address
//   mem_ready           : request accepted (handshake completes on mem_req & mem_ready)
//   mem_rvalid/rdata    : refill beats, word 0 first, only honoured while filling
//   hit_count/miss_count: lookup counters (live only with ICACHE_STATS_EN defined)
//   dbg_state           : current FSM state
// Handshake: mem_req rises on entry to REQ and, together with mem_addr, holds
// steady until a cycle with mem_ready=1; the cache then waits for exactly
// WORDS_PER_LINE mem_rvalid beats, which may have gaps of any length.
// Optional feature macro: ICACHE_STATS_EN.
module mips_icache
    import mips_icache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [1:0]  dbg_state
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int LB = $clog2(LINES);
    localparam int AW = WB + LB;
    localparam int TW = 30 - AW;

    state_t         state;
    logic [31:0]    pc_q;
    logic           look_v;      // pc_q holds a lookup being compared this cycle
    logic           counted;     // the current hit has already been counted
    logic           fill_ret;    // lookup is the re-read after a refill: always presented
    logic           flush_pend;
    logic           mem_req_q;
    logic [LINES-1:0] valid;
    logic [TW-1:0]  tags [LINES];
    logic [WB-1:0]  fill_cnt;

    logic [LB-1:0]  q_line;
    logic [WB-1:0]  q_word;
    logic [TW-1:0]  q_tag;
    logic           hit_c;
    logic           accept;
    logic           fill_last;

    logic           ram_en;
    logic           ram_we;
    logic [AW-1:0]  ram_addr;
    logic [31:0]    ram_rdata;

    assign q_word = pc_q[WB+1:2];
    assign q_line = pc_q[AW+1:WB+2];
    assign q_tag  = pc_q[31:AW+2];

    assign hit_c     = fill_ret || (valid[q_line] && (tags[q_line] == q_tag));
    assign stall     = (state != ST_IDLE) || (look_v && !hit_c);
    assign accept    = (state == ST_IDLE) && en && !stall;
    assign fill_last = (fill_cnt == WB'(WORDS_PER_LINE - 1));

    assign instr     = (state == ST_IDLE && look_v && hit_c) ? ram_rdata : 32'd0;
    assign mem_req   = mem_req_q;
    assign mem_addr  = {pc_q[31:WB+2], {(WB+2){1'b0}}};
    assign dbg_state = state;

    // One RAM port: lookups read the incoming pc so data is ready in the
    // compare cycle, refill beats write, DONE re-reads the missed word.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = pc[AW+1:2];
        if (!rst) begin
            if (accept) begin
                ram_en = 1'b1;
            end else if (state == ST_FILL && mem_rvalid) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = {q_line, fill_cnt};
            end else if (state == ST_DONE) begin
                ram_en   = 1'b1;
                ram_addr = {q_line, q_word};
            end
        end
    end

    icache_data_ram #(
        .DEPTH (LINES * WORDS_PER_LINE),
        .AW    (AW)
    ) u_data_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem_rdata),
        .rdata (ram_rdata)
    );

    // Tags need no reset: a tag is only trusted when its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_FILL && mem_rvalid && fill_last) begin
            tags[q_line] <= q_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc_q       <= 32'd0;
            look_v     <= 1'b0;
            counted    <= 1'b0;
            fill_ret   <= 1'b0;
            flush_pend <= 1'b0;
            mem_req_q  <= 1'b0;
            valid      <= '0;
            fill_cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // A detected miss proceeds even with en=0; en only
                    // gates accepting the next pc.
                    if (look_v && !hit_c) begin
                        state     <= ST_REQ;
                        mem_req_q <= 1'b1;
                        look_v    <= 1'b0;
                    end else begin
                        if (look_v) begin
                            counted <= 1'b1;
                        end
                        if (accept) begin
                            pc_q     <= pc;
                            look_v   <= 1'b1;
                            counted  <= 1'b0;
                            fill_ret <= 1'b0;
                        end
                    end
                    // Clearing at the accept edge makes that lookup miss.
                    if (flush) begin
                        valid <= '0;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        fill_cnt  <= '0;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_last) begin
                            valid[q_line] <= !(flush_pend || flush);
                            state         <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    look_v     <= 1'b1;
                    fill_ret   <= 1'b1;
                    counted    <= 1'b1;
                    flush_pend <= 1'b0;
                    if (flush_pend || flush) begin
                        valid <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // Each lookup is counted once in its compare cycle; refill re-reads are not lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= 32'd0;
            miss_q <= 32'd0;
        end else if (state == ST_IDLE && look_v) begin
            if (!hit_c) begin
                miss_q <= sat_inc(miss_q);
            end else if (!counted) begin
                hit_q <= sat_inc(hit_q);
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

    logic unused_bits;
    assign unused_bits = ^{pc[1:0], pc_q[1:0], counted};

endmodule

// File: tb/tb_mips_icache.sv
// tb_mips_icache: self-checking bench for mips_icache. A reference model keeps
// the resident line address per line index and a backing memory; a driver task
// plays the CPU and the memory for one fetch and reports what it observed.
module tb_mips_icache;
    import mips_icache_pkg::*;

    localparam int LINES = 16;
    localparam int WPL   = 4;
`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    bit [31:0] bmem [bit [31:0]];      // backing memory overrides
    bit [31:0] resident [int];         // line index -> resident line base address
    int        m_hit = 0;
    int        m_miss = 0;

    mips_icache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pc         (pc),
        .flush      (flush),
        .instr      (instr),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        if (bmem.exists(w)) return bmem[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Returns 1 on a hit; a miss makes the line resident.
    function automatic bit model_lookup(input logic [31:0] a, input bit fl);
        int        li;
        bit [31:0] base;
        if (fl) resident.delete();
        base = a & ~32'(WPL * 4 - 1);
        li   = int'((a / (WPL * 4)) % LINES);
        if (resident.exists(li) && resident[li] == base) begin
            m_hit++;
            return 1'b1;
        end
        resident[li] = base;
        m_miss++;
        return 1'b0;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with stall=0. Performs one lookup of a and, on a
    // miss, serves the refill. Returns at the negedge where instr is presented
    // (or right after an aborting reset) with en=0.
    task automatic fetch(input logic [31:0] a, input int wait_cyc, input int gap_pct,
                         input bit fl_accept, input bit fl_fill, input int abort_beat,
                         output bit o_miss, output int o_cyc, output int o_exp_cyc,
                         output logic [31:0] o_instr, output int o_proto);
        logic [31:0] base;
        int beats, phase, k, fill_cyc, n;
        base = a & ~32'(WPL * 4 - 1);
        o_proto = 0; o_cyc = 0; o_exp_cyc = -1;
        pc = a; en = 1'b1; flush = fl_accept;
        @(negedge clk);                       // compare cycle
        flush = 1'b0;
        o_miss = stall;
        o_instr = instr;
        if (!stall) begin
            en = 1'b0;
            return;
        end
        if (mem_req !== 1'b0) o_proto++;
        en = 1'($urandom_range(0, 1));
        pc = $urandom;                        // held pc must not matter while stalled
        phase = 0; k = 0; beats = 0; fill_cyc = 0; n = 0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            n = i;
            mem_ready = 1'b0; mem_rvalid = 1'b0; flush = 1'b0; rst = 1'b0;
            if (!stall || phase == 3) break;
            if (phase == 0) begin
                k++;
                if (mem_req !== 1'b1 || mem_addr !== base) o_proto++;
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                if (k == wait_cyc) begin
                    mem_ready = 1'b1;
                    phase = 1;
                end
            end else if (phase == 1) begin
                fill_cyc++;
                if (mem_req !== 1'b0) o_proto++;
                if (fl_fill && fill_cyc == 2) flush = 1'b1;
                if ($urandom_range(0, 99) >= gap_pct) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(base + 32'(4 * beats));
                    beats++;
                    if (abort_beat != 0 && beats == abort_beat) begin
                        rst = 1'b1;
                        phase = 3;
                    end else if (beats == WPL) begin
                        phase = 2;
                        o_exp_cyc = i + 2;
                    end
                end
            end else begin
                if (mem_req !== 1'b0) o_proto++;
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
            end
        end
        o_cyc = n;
        o_instr = instr;
        mem_ready = 1'b0; mem_rvalid = 1'b0; flush = 1'b0; rst = 1'b0; en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resident.delete(); m_hit = 0; m_miss = 0;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (instr !== 32'd0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count);
        end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_directed();
        logic [31:0] seq [7];
        bit          exp_miss [7];
        bit miss, eh; int cyc, ecyc, proto; logic [31:0] ins;
        seq = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h440, 32'h40};
        exp_miss = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bmem[32'h40] = 32'h11; bmem[32'h44] = 32'h22;
        bmem[32'h48] = 32'h33; bmem[32'h4C] = 32'h44;
        for (int i = 0; i < 7; i++) begin
            eh = model_lookup(seq[i], 1'b0);
            fetch(seq[i], 2, 0, 1'b0, 1'b0, 0, miss, cyc, ecyc, ins, proto);
            n_cmp++; if (miss !== exp_miss[i]) begin
                n_err++; $display("FAIL dir_miss[%0d] pc=%h: got %b want %b", i, seq[i], miss, exp_miss[i]);
            end
            n_cmp++; if (ins !== mem_word(seq[i])) begin
                n_err++; $display("FAIL dir_instr[%0d] pc=%h: got %h want %h", i, seq[i], ins, mem_word(seq[i]));
            end
            if (exp_miss[i]) begin
                n_cmp++; if (cyc !== 8) begin
                    n_err++; $display("FAIL dir_penalty[%0d]: got %0d want 8", i, cyc);
                end
                n_cmp++; if (proto !== 0) begin
                    n_err++; $display("FAIL dir_mem_if[%0d]: got %0d bad cycles want 0", i, proto);
                end
            end
            if (i == 0) begin
                n_cmp++; if (miss_count !== (STATS ? 32'd1 : 32'd0)) begin
                    n_err++; $display("FAIL dir_miss_count: got %0d want %0d", miss_count, STATS ? 1 : 0);
                end
            end
            if (i == 3) begin
                // en=0 freezes the presented hit while pc wanders.
                for (int j = 0; j < 3; j++) begin
                    pc = $urandom;
                    @(negedge clk);
                    n_cmp++; if (stall !== 1'b0 || instr !== 32'h44) begin
                        n_err++; $display("FAIL dir_freeze[%0d]: got stall=%b instr=%h want 0/44", j, stall, instr);
                    end
                end
                n_cmp++; if (hit_count !== (STATS ? 32'd3 : 32'd0)) begin
                    n_err++; $display("FAIL dir_hit_count: got %0d want %0d", hit_count, STATS ? 3 : 0);
                end
            end
        end
    endtask

    task automatic test_flush_fill();
        bit miss, eh; int cyc, ecyc, proto; logic [31:0] a, ins;
        a = 32'h0010_0000 | (32'($urandom_range(0, 255)) << 2);
        eh = model_lookup(a, 1'b0);
        fetch(a, $urandom_range(1, 3), 20, 1'b0, 1'b1, 0, miss, cyc, ecyc, ins, proto);
        resident.delete();
        n_cmp++; if (miss !== 1'b1 || cyc !== ecyc || ins !== mem_word(a)) begin
            n_err++; $display("FAIL flush_fill_refill: got miss=%b cyc=%0d instr=%h want 1/%0d/%h",
                              miss, cyc, ins, ecyc, mem_word(a));
        end
        eh = model_lookup(a, 1'b0);
        fetch(a, 1, 0, 1'b0, 1'b0, 0, miss, cyc, ecyc, ins, proto);
        n_cmp++; if (miss !== 1'b1 || ins !== mem_word(a)) begin
            n_err++; $display("FAIL flush_fill_relookup: got miss=%b instr=%h want 1/%h", miss, ins, mem_word(a));
        end
    endtask

    task automatic test_flush_idle();
        bit miss, eh; int cyc, ecyc, proto; logic [31:0] a, ins;
        a = 32'h0020_0000 | (32'($urandom_range(0, 255)) << 2);
        eh = model_lookup(a, 1'b0);
        fetch(a, 1, 0, 1'b0, 1'b0, 0, miss, cyc, ecyc, ins, proto);
        eh = model_lookup(a, 1'b0);
        fetch(a, 1, 0, 1'b0, 1'b0, 0, miss, cyc, ecyc, ins, proto);
        n_cmp++; if (miss !== 1'b0 || ins !== mem_word(a)) begin
            n_err++; $display("FAIL flush_idle_prehit: got miss=%b instr=%h want 0/%h", miss, ins, mem_word(a));
        end
        eh = model_lookup(a, 1'b1);
        fetch(a, 2, 10, 1'b1, 1'b0, 0, miss, cyc, ecyc, ins, proto);
        n_cmp++; if (miss !== 1'b1 || ins !== mem_word(a) || cyc !== ecyc) begin
            n_err++; $display("FAIL flush_idle_miss: got miss=%b instr=%h cyc=%0d want 1/%h/%0d",
                              miss, ins, cyc, mem_word(a), ecyc);
        end
    endtask

    task automatic test_reset_abort();
        bit miss, eh; int cyc, ecyc, proto; logic [31:0] a, ins;
        a = 32'h0030_0000 | (32'($urandom_range(0, 255)) << 2);
        eh = model_lookup(a, 1'b0);
        fetch(a, 2, 0, 1'b0, 1'b0, 2, miss, cyc, ecyc, ins, proto);
        resident.delete(); m_hit = 0; m_miss = 0;
        n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL abort_outputs: got mem_req=%b stall=%b want 0/0", mem_req, stall);
        end
        n_cmp++; if (miss_count !== 32'd0) begin
            n_err++; $display("FAIL abort_counter: got %0d want 0", miss_count);
        end
        eh = model_lookup(a, 1'b0);
        fetch(a, 1, 0, 1'b0, 1'b0, 0, miss, cyc, ecyc, ins, proto);
        n_cmp++; if (miss !== 1'b1 || ins !== mem_word(a) || cyc !== ecyc) begin
            n_err++; $display("FAIL abort_relookup: got miss=%b instr=%h cyc=%0d want 1/%h/%0d",
                              miss, ins, cyc, mem_word(a), ecyc);
        end
    endtask

    task automatic test_random();
        bit miss, eh, fa, ff; int cyc, ecyc, proto; logic [31:0] a, ins;
        for (int i = 0; i < 80; i++) begin
            a = (32'($urandom_range(0, 2)) << 12) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            fa = ($urandom_range(0, 9) == 0);
            ff = ($urandom_range(0, 9) == 0);
            eh = model_lookup(a, fa);
            fetch(a, $urandom_range(1, 3), $urandom_range(0, 40), fa, ff, 0, miss, cyc, ecyc, ins, proto);
            if (!eh && ff) resident.delete();
            n_cmp++; if (miss !== !eh) begin
                n_err++; $display("FAIL rnd_miss[%0d] pc=%h: got %b want %b", i, a, miss, !eh);
            end
            n_cmp++; if (ins !== mem_word(a)) begin
                n_err++; $display("FAIL rnd_instr[%0d] pc=%h: got %h want %h", i, a, ins, mem_word(a));
            end
            if (!eh) begin
                n_cmp++; if (cyc !== ecyc || proto !== 0) begin
                    n_err++; $display("FAIL rnd_refill[%0d] pc=%h: got cyc=%0d bad=%0d want %0d/0", i, a, cyc, proto, ecyc);
                end
            end
        end
        @(negedge clk);
        n_cmp++; if (hit_count !== (STATS ? 32'(m_hit) : 32'd0) || miss_count !== (STATS ? 32'(m_miss) : 32'd0)) begin
            n_err++; $display("FAIL rnd_counters: got %0d/%0d want %0d/%0d", hit_count, miss_count,
                              STATS ? m_hit : 0, STATS ? m_miss : 0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_flush_fill();
        test_flush_idle();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_icache.md
MIPS_ICACHE -- requirements
Module: mips_icache

Interface
REQ-001 The block SHALL declare parameter LINES, default 16, meaning the number of direct-mapped cache lines (power of two, at least 2).
REQ-002 The block SHALL declare parameter WORDS_PER_LINE, default 4, meaning the 32-bit words per line (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: global pipeline enable.
REQ-006 The block SHALL have port pc, input, 32 bits: fetch address from the CPU; bits [1:0] are ignored.
REQ-007 The block SHALL have port flush, input, 1 bit: request to invalidate all lines.
REQ-008 The block SHALL have port instr, output, 32 bits: the instruction for the pc sampled in the previous accepted cycle.
REQ-009 The block SHALL have port stall, output, 1 bit: high when instr is not valid and the CPU must hold its pc.
REQ-010 The block SHALL have port mem_req, output, 1 bit: line refill request.
REQ-011 The block SHALL have port mem_addr, output, 32 bits: line-aligned refill address.
REQ-012 The block SHALL have port mem_ready, input, 1 bit: the memory accepts the request.
REQ-013 The block SHALL have port mem_rvalid, input, 1 bit: refill data beat valid.
REQ-014 The block SHALL have port mem_rdata, input, 32 bits: refill data beat.
REQ-015 The block SHALL have ports hit_count and miss_count, outputs, 32 bits each: performance counters.

Function
REQ-016 Address split SHALL be: word index pc[log2(WPL)+1:2], line index the next log2(LINES) bits, tag the remaining upper bits.
REQ-017 In IDLE, when en=1 and stall=0, the block SHALL register pc; on a tag match with the valid bit set, the next cycle SHALL present instr=data with stall=0 (1-cycle hit latency).
REQ-018 On a miss, the block SHALL assert stall=1 in the compare cycle and move to REQ.
REQ-019 The FSM states SHALL be IDLE, REQ, FILL and DONE.
REQ-020 In REQ, the block SHALL hold mem_req=1 and mem_addr = the missed pc with its low log2(WPL)+2 bits zeroed, stable until mem_req&mem_ready, then move to FILL.
REQ-021 In FILL, mem_req SHALL be 0; each mem_rvalid beat SHALL write word 0,1,…,WPL-1 in order; on the last beat the tag and valid bit SHALL be written and the FSM SHALL move to DONE.
REQ-022 In DONE, the block SHALL re-look-up the saved pc, return to IDLE, and drive stall=0 with correct instr in the following cycle.
REQ-023 Miss penalty SHALL be 1 (detect) + request wait + WPL beats + 1 (DONE) cycles.
REQ-024 stall SHALL remain continuously high from miss detection until the refilled instr is presented.
REQ-025 en=0 SHALL freeze the pc register and IDLE lookups; REQ/FILL handshakes SHALL continue regardless of en, so no beats are lost.
REQ-026 mem_rvalid outside FILL SHALL be ignored.
REQ-027 flush in IDLE SHALL clear all valid bits at the next edge, and a lookup in that same cycle SHALL be treated as a miss.
REQ-028 flush in REQ/FILL/DONE SHALL be latched and applied on entry to IDLE; the refilled line SHALL NOT be marked valid in that case.
REQ-029 The pc address on the word-index wrap from the last word of line L to line L+1 SHALL be treated as an independent lookup.

Reset
REQ-030 With rst=1 at an edge, the block SHALL enter IDLE, clear all valid bits and pending flush, and drive mem_req=0, stall=0, instr=0 and counters=0.
REQ-031 Reset during REQ/FILL SHALL abort the refill with no line marked valid; the memory side shares rst.

Configuration
REQ-032 When ICACHE_STATS_EN is defined, hit_count and miss_count SHALL each increment once per IDLE lookup hit/miss and saturate at 0xFFFFFFFF.
REQ-033 When ICACHE_STATS_EN is undefined, both counters SHALL be tied to 0 with no counter flops, and the ports SHALL remain present.

Structure
REQ-034 Package mips_icache_pkg SHALL hold the FSM state enum and the default LINES/WORDS_PER_LINE constants.
REQ-035 The design SHALL contain exactly one sub-module, icache_data_ram: synchronous-read, single-write-port, LINES*WPL x 32 words.

Verification
REQ-036 Reset, then pc=0x00000040: the bench SHALL see stall=1 next cycle, then mem_req=1 with mem_addr=0x00000040.
REQ-037 mem_ready after 2 cycles, beats 0x11,0x22,0x33,0x44: the bench SHALL see stall=0 with instr=0x11 exactly 1+2+4+1 cycles after the miss, and miss_count=1.
REQ-038 Then pc=0x44, 0x48, 0x4C: the bench SHALL see instr=0x22, 0x33, 0x44 back-to-back with stall=0 and hit_count=3.
REQ-039 pc=0x440 (same line index, different tag): the bench SHALL see a miss with mem_addr=0x440; re-reading 0x40 SHALL also miss.
REQ-040 flush asserted during FILL: the refill SHALL complete, stall SHALL drop, and the next lookup of the same pc SHALL miss again.
REQ-041 rst asserted on the second beat of FILL: mem_req SHALL be 0, stall SHALL be 0, and the next lookup of that line SHALL miss.
